// File: rtl/kb_pkg.sv
// Shared constants, FSM state type and set-2 to ASCII translation for the
// keyboard scan path.
package kb_pkg;

  localparam logic [7:0] KB_BRK    = 8'hF0;
  localparam logic [7:0] KB_EXT    = 8'hE0;
  localparam logic [7:0] KB_LSHIFT = 8'h12;
  localparam logic [7:0] KB_RSHIFT = 8'h59;
  localparam logic [7:0] KB_CAPS   = 8'h58;
  localparam logic [7:0] KB_SPACE  = 8'h29;
  localparam logic [7:0] KB_ENTER  = 8'h5A;
  localparam logic [7:0] KB_BKSP   = 8'h66;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} kb_state_e;

  // Returns {hit, ascii}; letters use 'upper', digits use 'shift' only.
  function automatic logic [8:0] scan_to_ascii(input logic [7:0] code,
                                               input logic       upper,
                                               input logic       shift);
    logic [7:0] letter;
    logic [7:0] digit;
    logic [7:0] sym;
    logic [8:0] res;
    letter = '0;
    digit  = '0;
    sym    = '0;
    res    = '0;
    case (code)
      8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
      8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
      8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
      8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
      8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
      8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
      8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
      8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
      8'h35: letter = "y";  8'h1A: letter = "z";
      8'h16: begin digit = "1"; sym = "!"; end
      8'h1E: begin digit = "2"; sym = "@"; end
      8'h26: begin digit = "3"; sym = "#"; end
      8'h25: begin digit = "4"; sym = "$"; end
      8'h2E: begin digit = "5"; sym = "%"; end
      8'h36: begin digit = "6"; sym = "^"; end
      8'h3D: begin digit = "7"; sym = "&"; end
      8'h3E: begin digit = "8"; sym = "*"; end
      8'h46: begin digit = "9"; sym = "("; end
      8'h45: begin digit = "0"; sym = ")"; end
      KB_SPACE: res = {1'b1, 8'h20};
      KB_ENTER: res = {1'b1, 8'h0D};
      KB_BKSP:  res = {1'b1, 8'h08};
      default: ;
    endcase
    if (letter != '0)
      res = {1'b1, upper ? (letter - 8'h20) : letter};
    else if (digit != '0)
      res = {1'b1, shift ? sym : digit};
    return res;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Circular character FIFO with extra-MSB pointers; a pop frees the slot for
// a simultaneous push even when full.
module char_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [7:0]  r_mem [DEPTH];
  logic        w_do_pop;
  logic        w_do_push;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/kb_scan_controller.sv
// PS/2 scan-code sequencer: synchronises the ready strobe, decodes make/break/
// extended prefixes, tracks modifiers and queues translated ASCII characters.
module kb_scan_controller
  import kb_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ERR_W = 4
) (
  input  logic             CLOCK_50,
  input  logic             rst_l,
  input  logic [7:0]       scan_code,
  input  logic             scan_rdy,
  input  logic             parity_error,
  output logic [7:0]       char_out,
  output logic             char_valid,
  input  logic             char_pop,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             shift_state,
  output logic             caps_state,
  output logic [ERR_W-1:0] err_count
);

  kb_state_e        r_state;
  logic             r_rdy_s1, r_rdy_s2, r_rdy_d;
  logic             r_lshift, r_rshift, r_caps, r_ovf;
  logic [ERR_W-1:0] r_err;
  logic             w_evt, w_shift, w_push, w_drop, w_full, w_empty;
  logic [8:0]       w_map;

  assign w_evt       = r_rdy_s2 & ~r_rdy_d;
  assign w_shift     = r_lshift | r_rshift;
  assign w_map       = scan_to_ascii(scan_code, w_shift ^ r_caps, w_shift);
  // Prefix and modifier codes never map, so a hit in IDLE is always printable.
  assign w_push      = w_evt & ~parity_error & (r_state == IDLE) & w_map[8];
  assign w_drop      = w_push & w_full & ~(char_pop & ~w_empty);
  assign char_valid  = ~w_empty;
  assign shift_state = w_shift;
  assign caps_state  = r_caps;
  assign overflow    = r_ovf;
  assign err_count   = r_err;

  always_ff @(posedge CLOCK_50 or negedge rst_l) begin
    if (!rst_l) begin
      r_rdy_s1 <= 1'b0;
      r_rdy_s2 <= 1'b0;
      r_rdy_d  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_rdy_s1 <= scan_rdy;
      r_rdy_s2 <= r_rdy_s1;
      r_rdy_d  <= r_rdy_s2;
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_l) begin
    if (!rst_l) begin
      r_state  <= IDLE;
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_caps   <= 1'b0;
      r_err    <= '0;
    end else if (w_evt) begin
      if (parity_error) begin
        r_state <= IDLE;
        if (r_err != '1) r_err <= r_err + ERR_W'(1);
      end else begin
        case (r_state)
          IDLE: begin
            if (scan_code == KB_BRK)         r_state <= BRK;
            else if (scan_code == KB_EXT)    r_state <= EXT;
            else if (scan_code == KB_LSHIFT) r_lshift <= 1'b1;
            else if (scan_code == KB_RSHIFT) r_rshift <= 1'b1;
            else if (scan_code == KB_CAPS)   r_caps <= ~r_caps;
          end
          BRK: begin
            if (scan_code == KB_LSHIFT) r_lshift <= 1'b0;
            if (scan_code == KB_RSHIFT) r_rshift <= 1'b0;
            r_state <= IDLE;
          end
          EXT:     r_state <= (scan_code == KB_BRK) ? EXT_BRK : IDLE;
          EXT_BRK: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (CLOCK_50),
    .i_rst_n (rst_l),
    .i_push  (w_push),
    .i_data  (w_map[7:0]),
    .i_pop   (char_pop),
    .o_data  (char_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_kb_scan_controller.sv
// Self-checking bench for kb_scan_controller: directed scenarios followed by
// randomized key traffic against a keyboard/queue reference model.
module tb_kb_scan_controller;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned ERR_W = 4;

  logic             CLOCK_50 = 1'b0;
  logic             rst_l = 1'b0;
  logic [7:0]       scan_code = '0;
  logic             scan_rdy = 1'b0;
  logic             parity_error = 1'b0;
  logic [7:0]       char_out;
  logic             char_valid;
  logic             char_pop = 1'b0;
  logic             overflow;
  logic             ovf_clr = 1'b0;
  logic             shift_state;
  logic             caps_state;
  logic [ERR_W-1:0] err_count;

  kb_scan_controller #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .CLOCK_50     (CLOCK_50),
    .rst_l        (rst_l),
    .scan_code    (scan_code),
    .scan_rdy     (scan_rdy),
    .parity_error (parity_error),
    .char_out     (char_out),
    .char_valid   (char_valid),
    .char_pop     (char_pop),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
    .shift_state  (shift_state),
    .caps_state   (caps_state),
    .err_count    (err_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: keyboard state as flags plus a bounded character queue.
  logic [7:0] letter_code [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                   8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                   8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                   8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_code [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                  8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  string      digit_chr = "1234567890";
  string      digit_sym = "!@#$%^&*()";

  logic [7:0]  mq[$];
  bit          m_brk, m_ext, m_lsh, m_rsh, m_caps, m_ovf;
  int unsigned m_errs;

  task automatic model_reset();
    mq.delete();
    m_brk = 0; m_ext = 0; m_lsh = 0; m_rsh = 0; m_caps = 0; m_ovf = 0; m_errs = 0;
  endtask

  task automatic model_translate(input logic [7:0] code, output bit hit, output logic [7:0] ch);
    bit sh;
    sh  = m_lsh | m_rsh;
    hit = 0;
    ch  = '0;
    for (int i = 0; i < 26; i++)
      if (code == letter_code[i]) begin
        hit = 1;
        ch  = 8'((sh ^ m_caps) ? 8'h41 + i : 8'h61 + i);
      end
    for (int i = 0; i < 10; i++)
      if (code == digit_code[i]) begin
        hit = 1;
        ch  = sh ? digit_sym[i] : digit_chr[i];
      end
    if (code == 8'h29) begin hit = 1; ch = 8'h20; end
    if (code == 8'h5A) begin hit = 1; ch = 8'h0D; end
    if (code == 8'h66) begin hit = 1; ch = 8'h08; end
  endtask

  task automatic model_byte(input logic [7:0] code, input logic perr);
    bit         hit;
    logic [7:0] ch;
    if (perr) begin
      if (m_errs < 15) m_errs++;
      m_brk = 0; m_ext = 0;
    end else if (m_ext) begin
      if (m_brk) begin m_brk = 0; m_ext = 0; end
      else if (code == 8'hF0) m_brk = 1;
      else m_ext = 0;
    end else if (m_brk) begin
      if (code == 8'h12) m_lsh = 0;
      if (code == 8'h59) m_rsh = 0;
      m_brk = 0;
    end else if (code == 8'hF0) m_brk = 1;
    else if (code == 8'hE0) m_ext = 1;
    else if (code == 8'h12) m_lsh = 1;
    else if (code == 8'h59) m_rsh = 1;
    else if (code == 8'h58) m_caps = ~m_caps;
    else begin
      model_translate(code, hit, ch);
      if (hit) begin
        if (mq.size() < DEPTH) mq.push_back(ch);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, 32'(char_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, ".head"}, 32'(char_out), 32'(mq[0]));
    chk({tag, ".shift"}, 32'(shift_state), 32'(m_lsh | m_rsh));
    chk({tag, ".caps"}, 32'(caps_state), 32'(m_caps));
    chk({tag, ".err"}, 32'(err_count), m_errs);
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Raises scan_rdy for 'hold' sampled edges; pop/clr land on the push cycle.
  task automatic send(input logic [7:0] code, input logic perr, input int unsigned hold,
                      input bit pop, input bit clr, input bit lat);
    @(negedge CLOCK_50);
    scan_code = code; parity_error = perr; scan_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLOCK_50);
      if (i == hold) scan_rdy = 1'b0;
      char_pop = (i == 2) && pop;
      ovf_clr  = (i == 2) && clr;
      if (lat && i < 3) chk("lat_early", 32'(char_valid), 0);
      if (lat && i == 3) chk("lat_valid", 32'(char_valid), 1);
    end
    if (pop && mq.size() != 0) void'(mq.pop_front());
    if (clr) m_ovf = 0;
    model_byte(code, perr);
  endtask

  task automatic key(input logic [7:0] code);
    send(code, 1'b0, $urandom_range(1, 5), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_one(input string tag);
    @(negedge CLOCK_50);
    chk({tag, ".pvalid"}, 32'(char_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, ".pdata"}, 32'(char_out), 32'(mq[0]));
    char_pop = 1'b1;
    @(negedge CLOCK_50);
    char_pop = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".valid"}, 32'(char_valid), 0);
    chk({tag, ".char"}, 32'(char_out), 0);
    chk({tag, ".ovf"}, 32'(overflow), 0);
    chk({tag, ".shift"}, 32'(shift_state), 0);
    chk({tag, ".caps"}, 32'(caps_state), 0);
    chk({tag, ".err"}, 32'(err_count), 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    check_reset_outputs("rst");
    rst_l = 1'b1;

    // Press/release 'a' with latency check, then pop.
    send(8'h1C, 1'b0, 5, 1'b0, 1'b0, 1'b1);
    key(8'hF0); key(8'h1C);
    compare_all("a");
    chk("a_char", 32'(char_out), 32'h61);
    pop_one("a");
    chk("a_drained", 32'(char_valid), 0);

    // Shifted digit, caps letter, shift XOR caps.
    key(8'h12); key(8'h1E); key(8'hF0); key(8'h1E); key(8'hF0); key(8'h12);
    chk("at_char", 32'(char_out), 32'h40);
    pop_one("at");
    key(8'h58); key(8'hF0); key(8'h58); key(8'h1C); key(8'hF0); key(8'h1C);
    chk("caps_on", 32'(caps_state), 1);
    chk("caps_A", 32'(char_out), 32'h41);
    pop_one("capsA");
    key(8'h12); key(8'h1C);
    chk("xor_a", 32'(char_out), 32'h61);
    pop_one("xor");
    key(8'hF0); key(8'h12); key(8'h58); key(8'hF0); key(8'h58);
    compare_all("norm");

    // Extended sequences are ignored.
    key(8'hE0); key(8'h12); key(8'hE0); key(8'h75); key(8'hE0); key(8'hF0); key(8'h75);
    chk("ext_shift", 32'(shift_state), 0);
    chk("ext_valid", 32'(char_valid), 0);
    compare_all("ext");

    // Parity error discards the pending break prefix.
    send(8'hF0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    key(8'h1C);
    chk("perr_cnt", 32'(err_count), 1);
    chk("perr_char", 32'(char_out), 32'h61);
    pop_one("perr");
    key(8'hF0); key(8'h1C);

    // Overflow, full push+pop, clear-vs-set, drain.
    for (int i = 0; i < 9; i++) begin key(8'h29); key(8'hF0); key(8'h29); end
    chk("ovf_set", 32'(overflow), 1);
    compare_all("full");
    send(8'h29, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    compare_all("full_pp");
    send(8'h29, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    chk("ovf_set_wins", 32'(overflow), 1);
    @(negedge CLOCK_50); ovf_clr = 1'b1;
    @(negedge CLOCK_50); ovf_clr = 1'b0; m_ovf = 0;
    chk("ovf_clr", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      chk("drain_sp", 32'(char_out), 32'h20);
      pop_one("drain");
    end
    chk("drain_empty", 32'(char_valid), 0);

    // Push and pop together while empty keeps the character.
    send(8'h1C, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    chk("empty_pp", 32'(char_valid), 1);
    pop_one("empty_pp");
    key(8'hF0); key(8'h1C);

    // Error counter saturation.
    for (int i = 0; i < 16; i++) send(8'h1C, 1'b1, 2, 1'b0, 1'b0, 1'b0);
    chk("err_sat", 32'(err_count), 15);
    compare_all("sat");

    // Reset after a break prefix.
    key(8'hF0);
    @(negedge CLOCK_50); rst_l = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge CLOCK_50); rst_l = 1'b1;
    model_reset();
    key(8'h1C);
    chk("midrst_char", 32'(char_out), 32'h61);
    compare_all("midrst");

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      logic [7:0]  code;
      r = $urandom_range(0, 99);
      if (r < 45)      code = letter_code[$urandom_range(0, 25)];
      else if (r < 57) code = digit_code[$urandom_range(0, 9)];
      else if (r < 63) code = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      else if (r < 66) code = 8'h58;
      else if (r < 78) code = 8'hF0;
      else if (r < 84) code = 8'hE0;
      else if (r < 92) begin
        r = $urandom_range(0, 2);
        code = (r == 0) ? 8'h29 : (r == 1) ? 8'h5A : 8'h66;
      end else code = 8'($urandom_range(0, 255));
      send(code, $urandom_range(0, 15) == 0, $urandom_range(1, 5),
           $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, 1'b0);
      compare_all("rnd");
      if ($urandom_range(0, 9) < 4) pop_one("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kb_scan_controller.md
Name: kb_scan_controller

Overview:
- Sequences the PS/2 keyboard receiver's byte stream (code, ready strobe, parity flag) into typed characters for the typewriter display path.
- Synchronises the receiver's ready strobe into the CLOCK_50 domain and decodes make, break (F0) and extended (E0) prefixes.
- Tracks shift and caps-lock state, translates set-2 make codes to ASCII, and buffers the characters in a small FIFO drained by a pop handshake.

Parameters:
- DEPTH, 8, character FIFO entries; must be a power of 2 and at least 2.
- ERR_W, 4, width of the saturating parity-error counter.

Ports:
- CLOCK_50  in  1  system clock.
- rst_l  in  1  asynchronous active-low reset.
- scan_code  in  8  byte from the keyboard receiver; stable while scan_rdy is high.
- scan_rdy  in  1  receiver ready strobe (PS/2 clock domain).
- parity_error  in  1  receiver parity flag; qualifies the same byte as scan_code.
- char_out  out  8  ASCII character at the FIFO head.
- char_valid  out  1  FIFO not empty.
- char_pop  in  1  consumer takes char_out this cycle.
- overflow  out  1  sticky: a character was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.
- shift_state  out  1  either shift key is held.
- caps_state  out  1  caps-lock toggle state.
- err_count  out  ERR_W  saturating count of parity-error bytes.

Behaviour:
Reset:
- All outputs are 0 at reset: char_valid=0, char_out=0, overflow=0, shift_state=0, caps_state=0, err_count=0.
- The FIFO is emptied, the FSM goes to IDLE and the synchroniser flops are cleared.
- Reset asserted mid-sequence (for example after F0) discards the pending prefix.

Sync and byte event:
- scan_rdy passes through a 2-flop synchroniser.
- A byte event is the rising edge of the synchronised signal: exactly one event per rdy pulse, however long the pulse.
- scan_code and parity_error are sampled in the event cycle.
- Latency: a character from an accepted byte shows char_valid=1 after the 3rd CLOCK_50 rising edge that samples scan_rdy high.

Parity error:
- The byte is discarded and the FSM returns to IDLE.
- err_count increments and saturates at all-ones.

FSM (advances only on byte events):
- IDLE:
  - F0 -> BRK.
  - E0 -> EXT.
  - Any other byte is a make code: apply make, stay in IDLE.
- BRK: the byte is a break code; apply break, go to IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - Any other byte: extended make, ignored (no character, no shift change, including E0 12); go to IDLE.
- EXT_BRK: extended break, ignored; go to IDLE.

Make codes:
- 12 sets lshift; 59 sets rshift.
- 58 toggles caps.
- Mapped printable codes push one character. Key repeat (a repeated make with no break) pushes again.
- Unmapped codes are ignored.

Break codes:
- 12 clears lshift; 59 clears rshift.
- All other break codes are ignored.

Translation:
- shift_state = lshift | rshift.
- Letters: uppercase when shift_state XOR caps_state, otherwise lowercase.
- Digits: the digit unshifted; with shift, the US-layout symbol (!@#$%^&*()). Caps has no effect on digits.
- 29 -> 0x20 (space), 5A -> 0x0D (enter), 66 -> 0x08 (backspace); not affected by shift or caps.

FIFO:
- Circular buffer with log2(DEPTH)+1-bit read and write pointers; char_out is the head entry.
- Pop with char_valid=0 is ignored.
- Push while full without a pop in the same cycle: the character is dropped and overflow is set.
- Push and pop in the same cycle are both performed, including when full and when empty (the empty case still leaves char_valid=1 next cycle).
- Pointers wrap modulo 2*DEPTH.
- ovf_clr clears overflow. If ovf_clr and a new overflow occur in the same cycle, set wins.

Decomposition:
- Package kb_pkg holds:
  - prefix constants (KB_BRK=8'hF0, KB_EXT=8'hE0);
  - key constants (LSHIFT 12, RSHIFT 59, CAPS 58, SPACE 29, ENTER 5A, BKSP 66);
  - the FSM state enum (IDLE, BRK, EXT, EXT_BRK);
  - a function scan_to_ascii(code, upper, shift) returning {hit, ascii[7:0]}.
- One sub-module, char_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty), instantiated once.

Test Plan:
- Press and release a: 1C, F0 1C -> one character 0x61; char_valid=1 on the 3rd CLOCK_50 edge after rdy rises; pop returns 0x61 and char_valid drops.
- Shifted digit and caps: 12 1E F0 1E F0 12 -> 0x40 ('@'); then 58 F0 58 1C F0 1C -> 0x41 ('A') with caps_state=1; then 12 1C -> 0x61 (shift XOR caps).
- Extended sequences: E0 12 E0 75 E0 F0 75 -> no character pushed, shift_state stays 0, FSM back in IDLE.
- Parity error: byte F0 sent with parity_error=1, then 1C -> err_count=1 and 0x61 pushed (prefix discarded); 16 errored bytes with ERR_W=4 -> err_count holds 15.
- Overflow: 9 presses of 29 with no pops, DEPTH=8 -> 8 entries of 0x20 and overflow=1; pop and push in the same cycle while full keeps the count at 8; ovf_clr -> overflow=0.
- Reset mid-sequence: send F0, assert rst_l=0, release, send 1C -> character 0x61 pushed (treated as a make); all outputs read 0 during reset.
